// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte-serial UART transmitter, LSB first.
// Bytes are accepted on a valid/ready handshake into a small queue. They go out as back-to-back
// frames, with no idle gap, for as long as the queue holds data.
// Optional feature: define UART_TX_FIFO_EN to get a FIFO_DEPTH-entry circular buffer. Without it,
// the queue is a single holding register with a full flag.
module uart_tx #(
  parameter int unsigned clk_freq_hz = 30000000,
  parameter int unsigned baud_rate   = 115200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned BaudDiv = clk_freq_hz / baud_rate;
  localparam int unsigned CntW    = $clog2(BaudDiv);
  localparam int unsigned LvlW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(BaudDiv - 1);

  logic       push;
  logic       pop;
  logic       empty;
  logic       full;
  logic [7:0] head;

  // No bypass: o_ready only follows the registered occupancy.
  assign o_ready = !full;
  assign push    = i_valid && o_ready;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [LvlW-1:0] count_q;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Wrapping pointers and occupancy count; push and pop together leave the count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + LvlW'(1);
        2'b01:   count_q <= count_q - LvlW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full    = (count_q == LvlW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign o_level = count_q;
`else
  logic [7:0] hold_q;
  logic       full_q;

  // Single-entry holding register; a push wins over a pop in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      hold_q <= i_data;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full    = full_q;
  assign empty   = !full_q;
  assign head    = hold_q;
  assign o_level = LvlW'(full_q);
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy_q;
  logic            cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // The queue head is consumed whenever a new frame's start bit is launched.
  assign pop = !empty && ((state_q == StIdle) || (state_q == StStop && cnt_zero));

  // Frame sequencer: every bit is held for BaudDiv cycles, with registered line and busy outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= head;
            tx_q    <= 1'b0;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_zero) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            cnt_q     <= CntLoad;
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_zero) begin
            cnt_q <= CntLoad;
            if (bit_idx_q != 3'd7) begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: begin
          if (cnt_zero) begin
            if (!empty) begin
              // Chain straight into the next start bit with no idle gap.
              shift_q <= head;
              tx_q    <= 1'b0;
              cnt_q   <= CntLoad;
              state_q <= StStart;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with BAUD_DIV = 10.
// A sampling receiver model decodes the line so that byte order and frame spacing can be checked.
module tb_uart_tx;

  localparam int unsigned ClkHz = 1000;
  localparam int unsigned Baud  = 100;
  localparam int unsigned Depth = 8;
  localparam int          Frame = 100;
`ifdef UART_TX_FIFO_EN
  localparam int          Q = Depth;
`else
  localparam int          Q = 1;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_uart_tx;
  logic       o_busy;
  logic [3:0] o_level;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  int         rx_err = 0;

  uart_tx #(
    .clk_freq_hz (ClkHz),
    .baud_rate   (Baud),
    .FIFO_DEPTH  (Depth)
  ) u_dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_uart_tx (o_uart_tx),
    .o_busy    (o_busy),
    .o_level   (o_level)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rx_at(input int idx);
    if (idx < rx_q.size()) return int'(rx_q[idx]);
    return -1;
  endfunction

  // Receiver model: samples each bit mid-way and logs the byte and the start cycle of each frame.
  initial begin : rx_model
    bit         active;
    int         k;
    logic [9:0] sh;
    active = 1'b0;
    k      = 0;
    sh     = '0;
    forever begin
      @(posedge i_clk);
      #2;
      if (i_rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (!o_uart_tx) begin
          active = 1'b1;
          k      = 0;
          start_q.push_back(cyc);
        end
      end else begin
        k++;
        if (k % 10 == 5) sh[k/10] = o_uart_tx;
        if (k == 95) begin
          if (sh[0] != 1'b0 || sh[9] != 1'b1) rx_err++;
          rx_q.push_back(sh[8:1]);
          active = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output bit ok);
    ok      = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int t = 0; t < 1500; t++) begin
      if (rx_q.size() >= n) break;
      @(posedge i_clk);
      #1;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 3000; t++) begin
      if (!o_busy && o_level == 0) break;
      @(posedge i_clk);
      #1;
    end
    check(tag, o_busy, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    bit         ok;
    bit         ok2;
    int         bad;
    int         busy_n;
    int         n_acc;
    int         acc_cyc[16];
    bit         will;
    int         max_lvl;
    int         snap_acc;
    int         snap_lvl;
    int         snap_rdy;
    logic [9:0] frame;

    i_valid  = 1'b0;
    i_data   = '0;
    snap_acc = -1;
    snap_lvl = -1;
    snap_rdy = -1;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_line", o_uart_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);
    check("rst_level", o_level, 0);
    i_rst = 1'b0;
    bad    = 0;
    busy_n = 0;
    repeat (100) begin
      @(posedge i_clk);
      #1;
      if (o_uart_tx !== 1'b1) bad++;
      if (o_busy) busy_n++;
    end
    check("idle_line_low_cycles", bad, 0);
    check("idle_busy_cycles", busy_n, 0);
    check("idle_level", o_level, 0);

    // Single byte 0xA5 with cycle-exact waveform
    rx_q.delete();
    start_q.delete();
    send(8'hA5, ok);
    check("a5_accepted", ok, 1);
    check("a5_line_at_accept", o_uart_tx, 1);
    frame  = {1'b1, 8'hA5, 1'b0};
    bad    = 0;
    busy_n = 0;
    for (int k = 0; k < Frame; k++) begin
      @(posedge i_clk);
      #1;
      if (o_uart_tx !== frame[k/10]) bad++;
      if (o_busy) busy_n++;
    end
    check("a5_wave_errors", bad, 0);
    check("a5_busy_cycles", busy_n, 100);
    @(posedge i_clk);
    #1;
    check("a5_busy_after", o_busy, 0);
    check("a5_line_after", o_uart_tx, 1);
    wait_rx(1, "a5_rx_count");
    check("a5_rx_byte", rx_at(0), 32'hA5);

    // Back-to-back frames
    wait_idle("b2b_idle_before");
    rx_q.delete();
    start_q.delete();
    send(8'h55, ok);
    send(8'h0F, ok2);
    check("b2b_accepted", {ok, ok2}, 2'b11);
    wait_rx(2, "b2b_rx_count");
    check("b2b_rx_first", rx_at(0), 32'h55);
    check("b2b_rx_second", rx_at(1), 32'h0F);
    check("b2b_frame_spacing", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, Frame);

    // Backpressure: i_valid held high across 12 bytes
    wait_idle("bp_idle_before");
    rx_q.delete();
    start_q.delete();
    rx_err  = 0;
    n_acc   = 0;
    max_lvl = 0;
    i_data  = 8'h00;
    i_valid = 1'b1;
    for (int t = 0; t < 2000 && n_acc < 12; t++) begin
      will = o_ready;
      if (will) acc_cyc[n_acc] = cyc + 1;
      @(posedge i_clk);
      #1;
      if (will) begin
        n_acc++;
        i_data = 8'(n_acc);
      end
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      if (n_acc > 0 && cyc == acc_cyc[0] + 15) begin
        snap_acc = n_acc;
        snap_lvl = int'(o_level);
        snap_rdy = int'(o_ready);
      end
    end
    i_valid = 1'b0;
    check("bp_accepted", n_acc, 12);
    check("bp_burst_accepted", snap_acc, Q + 1);
    check("bp_level_full", snap_lvl, Q);
    check("bp_ready_low_full", snap_rdy, 0);
    check("bp_resume_first", acc_cyc[Q+1] - acc_cyc[0], 102);
    check("bp_resume_second", acc_cyc[Q+2] - acc_cyc[0], 202);
    check("bp_level_max", max_lvl, Q);
    wait_rx(12, "bp_rx_count");
    bad = 0;
    for (int i = 0; i < 12; i++) if (rx_at(i) != i) bad++;
    check("bp_rx_order_errors", bad, 0);
    bad = 0;
    for (int i = 1; i < 12 && i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != Frame) bad++;
    check("bp_gap_errors", bad, 0);
    check("bp_frame_errors", rx_err, 0);

    // Asynchronous reset during data bit 3 of 0x00
    wait_idle("rstm_idle_before");
    rx_q.delete();
    start_q.delete();
    send(8'h00, ok);
    repeat (46) @(posedge i_clk);
    #1;
    check("rstm_line_bit3", o_uart_tx, 0);
    check("rstm_busy_mid", o_busy, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("rstm_line_async", o_uart_tx, 1);
    check("rstm_busy_async", o_busy, 0);
    check("rstm_level_async", o_level, 0);
    check("rstm_ready_async", o_ready, 1);
    repeat (2) @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("rstm_busy_after", o_busy, 0);
    check("rstm_no_partial_rx", rx_q.size(), 0);
    rx_err = 0;
    send(8'h3C, ok);
    wait_rx(1, "rstm_rx_count");
    check("rstm_rx_byte", rx_at(0), 32'h3C);
    check("rstm_frame_errors", rx_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, 8N1, LSB first. It is the transmit counterpart of the SoC UART receiver and drives the board TX pin from the peripheral bus side. Bytes arrive over a valid/ready handshake into a small queue and go out as back-to-back frames with no idle gap while the queue is non-empty.

## Interface
- clk_freq_hz, 30000000: input clock frequency in Hz.
- baud_rate, 115200: line rate. BAUD_DIV = clk_freq_hz / baud_rate (integer division), must be ≥ 2.
- FIFO_DEPTH, 8: queue depth, power of two ≥ 2. Used only when UART_TX_FIFO_EN is defined.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  8  byte to send. Sampled only on an accepted handshake.
- i_valid  in  1  byte offered.
- o_ready  out  1  queue can accept. Equal to !full, combinational from the registered count.
- o_uart_tx  out  1  serial line, registered. Idle high.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
- Queue depth Q: Q = FIFO_DEPTH with the macro, Q = 1 without it. Push when i_valid && o_ready at a rising edge. Pop when the FSM loads the shifter.
- Simultaneous push and pop in one cycle: count is unchanged and both happen.
- When full, o_ready is low. There is no bypass, so a pop in the same cycle does not raise o_ready until the next cycle.
- Baud counter is $clog2(BAUD_DIV) bits wide. It loads BAUD_DIV-1 on entering each bit and decrements to 0. Every bit lasts exactly BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_uart_tx=1. If the queue is non-empty, pop the head into the shift register, set o_uart_tx←0, load the counter, and go to START.
  - START: when the counter reaches 0, drive shift[0], set bit_idx←0, and go to DATA.
  - DATA: when the counter reaches 0 and bit_idx<7, shift right, drive the next bit, and increment bit_idx. When bit_idx==7, set o_uart_tx←1 and go to STOP.
  - STOP: when the counter reaches 0 and the queue is non-empty, pop, set o_uart_tx←0, and go directly to START. Otherwise go to IDLE.
- i_valid may drop without a transfer. Unaccepted data is ignored.

## Timing
- Reset values: o_uart_tx=1, o_busy=0, o_level=0, o_ready=1, state IDLE, queue empty, counter 0.
- Reset is asynchronous at any point, including mid-frame. The line goes high immediately, the queue is flushed, and the partial frame is abandoned.
- Latency: a byte accepted at edge N into an idle, empty block drops the line after edge N+1. o_busy rises at the same edge.
- Frame length is 10·BAUD_DIV cycles:
  - start bit: cycles 0…BAUD_DIV-1
  - data bit k: starts at (k+1)·BAUD_DIV
  - stop bit: starts at 9·BAUD_DIV
- Back-to-back frames: the next start bit follows the stop bit with zero extra cycles.
- o_busy falls at the edge where STOP exits to IDLE, i.e. 10·BAUD_DIV cycles after the start edge of the last frame.
- Pop timing, for o_ready/o_level checks:
  - First byte: popped at the IDLE→START edge.
  - Subsequent bytes: popped at the STOP→START edge.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry circular buffer with wrapping read/write pointers of $clog2(FIFO_DEPTH) bits and a count of $clog2(FIFO_DEPTH)+1 bits. o_level ranges 0…FIFO_DEPTH.
- UART_TX_FIFO_EN undefined: a single holding register with a full flag. o_level is 0 or 1. FIFO_DEPTH is ignored.
- Frame format, FSM, and timing are identical in both builds.

## Test plan
- Reset: hold i_rst, then release. o_uart_tx=1, o_ready=1, o_busy=0, o_level=0, and the line stays high for 100 cycles with no input.
- Single byte: clk_freq_hz=1000, baud_rate=100 (BAUD_DIV=10). Send 0xA5. Line is low for exactly 10 cycles starting 1 cycle after accept, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high. o_busy is high for 100 cycles.
- Back-to-back: push 0x55 then 0x0F while the first is sending. Two contiguous 100-cycle frames with no idle gap. A loopback uart_rx decodes 0x55 then 0x0F.
- Backpressure: hold i_valid high for 12 bytes (0x00..0x0B).
  - o_ready drops at Q+1 bytes queued/in-flight: 2 without the macro, 9 with it (FIFO_DEPTH=8).
  - o_ready rises the cycle after each pop.
  - All 12 bytes arrive in order.
- Reset mid-frame: assert i_rst during data bit 3 of 0x00. The line goes high immediately. After release, the block is idle and a new byte 0x3C transmits correctly.
- Full-queue concurrency: with the macro, fill to FIFO_DEPTH and offer a byte in the pop cycle. It is not accepted that cycle, is accepted the next cycle, and o_level stays ≤ FIFO_DEPTH throughout.
